// File: rtl/fetch_decode_pipe.sv
// fetch_decode_pipe: IF/ID pipeline register for the 5-stage RV32I core.
// Captures the fetched PC/instruction every cycle, holds them on a load-use stall,
// and inserts FLUSH_CYCLES bubbles after a taken jump or branch.
// Optional macro FETCH_DECODE_PIPE_PERF_EN enables saturating flush/stall counters;
// without it the counter ports are tied to zero and no counter flops exist.
module fetch_decode_pipe #(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     FLUSH_CYCLES = 2,   // legal range 1..15
    parameter logic [XLEN-1:0] BUBBLE_INSTR = '0,
    parameter int unsigned     PERF_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [XLEN-1:0]   pre_address_pc,
    input  logic [XLEN-1:0]   instruction_fetch,
    input  logic              next_select,
    input  logic              branch_result,
    input  logic              load,
    output logic [XLEN-1:0]   pre_address_out,
    output logic [XLEN-1:0]   instruction,
    output logic              valid_out,
    output logic              flush_busy,
    output logic [PERF_W-1:0] perf_flush_cnt,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    // Reload value of the bubble countdown; the flush edge itself is the first bubble.
    localparam logic [3:0] RearmCnt = 4'(FLUSH_CYCLES - 1);

    typedef enum logic {
        StRun,
        StFlush
    } state_e;

    state_e            r_state;
    state_e            w_state_d;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_d;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   w_pc_d;
    logic [XLEN-1:0]   r_instr;
    logic [XLEN-1:0]   w_instr_d;
    logic              r_valid;
    logic              w_valid_d;
    logic              w_flush;
    logic              w_stall;

    assign w_flush = next_select | branch_result;

    // Next-state: flush beats countdown beats stall beats capture.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_pc_d    = r_pc;
        w_instr_d = r_instr;
        w_valid_d = r_valid;
        w_stall   = 1'b0;

        if (w_flush) begin
            // A flush during the countdown re-arms rather than accumulating bubbles.
            w_pc_d    = '0;
            w_instr_d = BUBBLE_INSTR;
            w_valid_d = 1'b0;
            w_cnt_d   = RearmCnt;
            w_state_d = (RearmCnt != 4'd0) ? StFlush : StRun;
        end else begin
            unique case (r_state)
                StFlush: begin
                    // Stall requests are ignored while bubbles are being inserted.
                    w_pc_d    = '0;
                    w_instr_d = BUBBLE_INSTR;
                    w_valid_d = 1'b0;
                    w_cnt_d   = r_cnt - 4'd1;
                    w_state_d = (r_cnt == 4'd1) ? StRun : StFlush;
                end
                StRun: begin
                    if (load) begin
                        w_stall = 1'b1;
                    end else begin
                        w_pc_d    = pre_address_pc;
                        w_instr_d = instruction_fetch;
                        w_valid_d = 1'b1;
                    end
                end
                default: begin
                    w_state_d = StRun;
                    w_cnt_d   = '0;
                end
            endcase
        end
    end

    // Pipeline and countdown registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StRun;
            r_cnt   <= '0;
            r_pc    <= '0;
            r_instr <= BUBBLE_INSTR;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_pc    <= w_pc_d;
            r_instr <= w_instr_d;
            r_valid <= w_valid_d;
        end
    end

    assign pre_address_out = r_pc;
    assign instruction     = r_instr;
    assign valid_out       = r_valid;
    assign flush_busy      = (r_cnt != 4'd0);

`ifdef FETCH_DECODE_PIPE_PERF_EN
    localparam logic [PERF_W-1:0] PerfOne = PERF_W'(1);

    logic [PERF_W-1:0] r_perf_flush;
    logic [PERF_W-1:0] r_perf_stall;

    // Saturating event counters; they stop at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_flush <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_flush && (r_perf_flush != '1)) begin
                r_perf_flush <= r_perf_flush + PerfOne;
            end
            if (w_stall && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + PerfOne;
            end
        end
    end

    assign perf_flush_cnt = r_perf_flush;
    assign perf_stall_cnt = r_perf_stall;
`else
    assign perf_flush_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_decode_pipe.sv
// Scoreboard bench for fetch_decode_pipe: two instances (FLUSH_CYCLES=2 default,
// and FLUSH_CYCLES=3 / PERF_W=2 / NOP bubble). Stimulus pushes hand-computed
// expectations; one monitor per instance pops and compares after each edge.
module tb_fetch_decode_pipe;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        v;
        logic        busy;
        logic [15:0] pf;
        logic [15:0] ps;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    exp_t qa[$];
    exp_t qb[$];

    // Instance A: default parameters.
    logic        a_rst = 1'b0, a_ns = 1'b0, a_br = 1'b0, a_ld = 1'b0;
    logic [31:0] a_pc = '0, a_in = '0, a_pco, a_ins;
    logic        a_v, a_busy;
    logic [15:0] a_pf, a_ps;

    fetch_decode_pipe dut_a (
        .clk               (clk),
        .rst               (a_rst),
        .pre_address_pc    (a_pc),
        .instruction_fetch (a_in),
        .next_select       (a_ns),
        .branch_result     (a_br),
        .load              (a_ld),
        .pre_address_out   (a_pco),
        .instruction       (a_ins),
        .valid_out         (a_v),
        .flush_busy        (a_busy),
        .perf_flush_cnt    (a_pf),
        .perf_stall_cnt    (a_ps)
    );

    // Instance B: three-cycle flush, 2-bit counters, NOP bubble.
    logic        b_rst = 1'b0, b_ns = 1'b0, b_br = 1'b0, b_ld = 1'b0;
    logic [31:0] b_pc = '0, b_in = '0, b_pco, b_ins;
    logic        b_v, b_busy;
    logic [1:0]  b_pf, b_ps;

    fetch_decode_pipe #(
        .XLEN         (32),
        .FLUSH_CYCLES (3),
        .BUBBLE_INSTR (32'h0000_0013),
        .PERF_W       (2)
    ) dut_b (
        .clk               (clk),
        .rst               (b_rst),
        .pre_address_pc    (b_pc),
        .instruction_fetch (b_in),
        .next_select       (b_ns),
        .branch_result     (b_br),
        .load              (b_ld),
        .pre_address_out   (b_pco),
        .instruction       (b_ins),
        .valid_out         (b_v),
        .flush_busy        (b_busy),
        .perf_flush_cnt    (b_pf),
        .perf_stall_cnt    (b_ps)
    );

    function automatic logic [15:0] perf(input int x);
`ifdef FETCH_DECODE_PIPE_PERF_EN
        return 16'(x);
`else
        return 16'(0 * x);
`endif
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s: got %h want %h", nm, fld, act, req);
        end
    endtask

    task automatic compare(input exp_t e, input logic [31:0] pc, input logic [31:0] ins,
                           input logic v, input logic busy, input logic [15:0] pf,
                           input logic [15:0] ps);
        chk(e.name, "pc", pc, e.pc);
        chk(e.name, "instr", ins, e.ins);
        chk(e.name, "valid", 32'(v), 32'(e.v));
        chk(e.name, "busy", 32'(busy), 32'(e.busy));
        chk(e.name, "perf_flush", 32'(pf), 32'(e.pf));
        chk(e.name, "perf_stall", 32'(ps), 32'(e.ps));
    endtask

    // Monitors: one expectation is consumed per clock edge after it was issued.
    initial begin : mon_a
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                compare(e, a_pco, a_ins, a_v, a_busy, a_pf, a_ps);
            end
        end
    end

    initial begin : mon_b
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (qb.size() > 0) begin
                e = qb.pop_front();
                compare(e, b_pco, b_ins, b_v, b_busy, {14'b0, b_pf}, {14'b0, b_ps});
            end
        end
    end

    task automatic step_a(input logic r, input logic [31:0] pc, input logic [31:0] ins,
                          input logic ns, input logic br, input logic ld,
                          input logic [31:0] epc, input logic [31:0] eins, input logic ev,
                          input logic eb, input int epf, input int eps, input string nm);
        exp_t e;
        @(negedge clk);
        a_rst = r; a_pc = pc; a_in = ins; a_ns = ns; a_br = br; a_ld = ld;
        e.pc = epc; e.ins = eins; e.v = ev; e.busy = eb;
        e.pf = perf(epf); e.ps = perf(eps); e.name = nm;
        qa.push_back(e);
    endtask

    task automatic step_b(input logic r, input logic [31:0] pc, input logic [31:0] ins,
                          input logic ns, input logic br, input logic ld,
                          input logic [31:0] epc, input logic [31:0] eins, input logic ev,
                          input logic eb, input int epf, input int eps, input string nm);
        exp_t e;
        @(negedge clk);
        b_rst = r; b_pc = pc; b_in = ins; b_ns = ns; b_br = br; b_ld = ld;
        e.pc = epc; e.ins = eins; e.v = ev; e.busy = eb;
        e.pf = perf(epf); e.ps = perf(eps); e.name = nm;
        qb.push_back(e);
    endtask

    initial begin
        // ---- Instance A: FLUSH_CYCLES=2, bubble 0 ----
        step_a(1, 32'h1234, 32'hdeadbeef, 1, 1, 1, 32'h0, 32'h0, 0, 0, 0, 0, "a_rst0");
        step_a(1, 32'h5678, 32'hcafef00d, 0, 1, 1, 32'h0, 32'h0, 0, 0, 0, 0, "a_rst1");
        step_a(0, 32'h00, 32'h00500093, 0, 0, 0, 32'h00, 32'h00500093, 1, 0, 0, 0, "a_s0");
        step_a(0, 32'h04, 32'h00A00113, 0, 0, 0, 32'h04, 32'h00A00113, 1, 0, 0, 0, "a_s4");
        step_a(0, 32'h08, 32'h002081B3, 0, 0, 0, 32'h08, 32'h002081B3, 1, 0, 0, 0, "a_s8");
        step_a(0, 32'h10, 32'h11111111, 0, 0, 0, 32'h10, 32'h11111111, 1, 0, 0, 0, "a_s10");
        step_a(0, 32'h14, 32'h22222222, 0, 0, 1, 32'h10, 32'h11111111, 1, 0, 0, 1, "a_st1");
        step_a(0, 32'h14, 32'h22222222, 0, 0, 1, 32'h10, 32'h11111111, 1, 0, 0, 2, "a_st2");
        step_a(0, 32'h14, 32'h22222222, 0, 0, 1, 32'h10, 32'h11111111, 1, 0, 0, 3, "a_st3");
        step_a(0, 32'h14, 32'h22222222, 0, 0, 0, 32'h14, 32'h22222222, 1, 0, 0, 3, "a_rel");
        step_a(0, 32'h18, 32'h33333333, 0, 1, 0, 32'h0, 32'h0, 0, 1, 1, 3, "a_fl1");
        step_a(0, 32'h1c, 32'h44444444, 0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 3, "a_fl2");
        step_a(0, 32'h20, 32'h55555555, 0, 0, 0, 32'h20, 32'h55555555, 1, 0, 1, 3, "a_res");
        // flush and stall together: flush wins, stall not counted
        step_a(0, 32'h24, 32'h66666666, 1, 0, 1, 32'h0, 32'h0, 0, 1, 2, 3, "a_fl_ld");
        step_a(0, 32'h24, 32'h66666666, 0, 0, 1, 32'h0, 32'h0, 0, 0, 2, 3, "a_cd_ld");
        // countdown done: stall now holds the bubble
        step_a(0, 32'h24, 32'h66666666, 0, 0, 1, 32'h0, 32'h0, 0, 0, 2, 4, "a_hold_b");
        step_a(0, 32'h28, 32'h77777777, 0, 0, 0, 32'h28, 32'h77777777, 1, 0, 2, 4, "a_cap");
        // reset while cnt=1
        step_a(0, 32'h2c, 32'h88888888, 0, 1, 0, 32'h0, 32'h0, 0, 1, 3, 4, "a_fl3");
        step_a(1, 32'h2c, 32'h88888888, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, "a_midrst");
        step_a(0, 32'h2c, 32'h99999999, 0, 0, 0, 32'h2c, 32'h99999999, 1, 0, 0, 0, "a_after");

        // ---- Instance B: FLUSH_CYCLES=3, bubble NOP, PERF_W=2 ----
        step_b(1, 32'hffff, 32'hffffffff, 1, 0, 1, 32'h0, 32'h13, 0, 0, 0, 0, "b_rst");
        step_b(0, 32'h100, 32'hAAAAAAAA, 0, 0, 0, 32'h100, 32'hAAAAAAAA, 1, 0, 0, 0, "b_cap");
        step_b(0, 32'h104, 32'hBBBBBBBB, 1, 0, 0, 32'h0, 32'h13, 0, 1, 1, 0, "b_fl1");
        step_b(0, 32'h104, 32'hBBBBBBBB, 1, 0, 0, 32'h0, 32'h13, 0, 1, 2, 0, "b_rearm");
        step_b(0, 32'h104, 32'hBBBBBBBB, 0, 0, 1, 32'h0, 32'h13, 0, 1, 2, 0, "b_cd_ld1");
        step_b(0, 32'h104, 32'hBBBBBBBB, 0, 0, 1, 32'h0, 32'h13, 0, 0, 2, 0, "b_cd_ld0");
        step_b(0, 32'h104, 32'hBBBBBBBB, 0, 0, 0, 32'h104, 32'hBBBBBBBB, 1, 0, 2, 0, "b_res");
        for (int i = 1; i <= 5; i++) begin
            step_b(0, 32'h108, 32'hCCCCCCCC, 0, 0, 1, 32'h104, 32'hBBBBBBBB, 1, 0, 2,
                   (i > 3) ? 3 : i, $sformatf("b_sat%0d", i));
        end
        step_b(0, 32'h108, 32'hCCCCCCCC, 0, 0, 0, 32'h108, 32'hCCCCCCCC, 1, 0, 2, 3, "b_end");

        // Drain: every issued expectation must have been consumed.
        repeat (3) @(posedge clk);
        #3;
        total++;
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL drain: pending a=%0d b=%0d want 0", qa.size(), qb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
